// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall encoding, exception codes and the EX-to-MEM field layout.
package mem_stage_pkg;
    localparam int STALL_WD     = 6;
    localparam int EX_TO_MEM_WD = 229;
    localparam int MEM_TO_WB_WD = 177;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd1;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    typedef struct packed {
        logic [31:0] badvaddr;
        logic [4:0]  excepttype;
        logic        in_delayslot;
        logic [31:0] pc;
        logic        cp0_we;
        logic [4:0]  cp0_addr;
        logic [2:0]  cp0_sel;
        logic [31:0] cp0_wdata;
        logic [3:0]  data_ram_sel;
        logic        inst_lb;
        logic        inst_lbu;
        logic        inst_lh;
        logic        inst_lhu;
        logic [31:0] hi_wdata;
        logic        hi_we;
        logic [31:0] lo_wdata;
        logic        lo_we;
        logic [3:0]  data_ram_wen;
        logic        data_ram_en;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: picks the addressed byte/half from the SRAM word and extends it.
module mem_stage_load_align (
    input  logic [31:0] rdata,
    input  logic [3:0]  sel,
    input  logic        lb,
    input  logic        lbu,
    input  logic        lh,
    input  logic        lhu,
    output logic [31:0] result
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        byte_v = sel[0] ? rdata[7:0] : sel[1] ? rdata[15:8] : sel[2] ? rdata[23:16] : rdata[31:24];
        half_v = sel[3] ? rdata[31:16] : rdata[15:0];
        result = (lb | lbu) ? {{24{lb & byte_v[7]}}, byte_v} :
                 (lh | lhu) ? {{16{lh & half_v[15]}}, half_v} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register, load alignment, precise exception report and write squash.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_fwd_bus,
    output logic [65:0]             mem_hilo_fwd,
    output logic                    exc_valid,
    output logic [4:0]              exc_code,
    output logic [31:0]             exc_pc,
    output logic [31:0]             exc_badvaddr,
    output logic                    exc_in_delayslot
);
    ex_mem_t     r_q, r_d;
    logic        fresh_q, fresh_d;
    logic        exc_hit, rf_we, hi_we, lo_we, cp0_we;
    logic [31:0] load_res, rf_wdata;
    logic        unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= '0;
            fresh_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            fresh_q <= fresh_d;
        end
    end

    // fresh marks an instruction that has not yet reported its exception
    always_comb begin
        r_d     = r_q;
        fresh_d = fresh_q & ~exc_valid;
        if (flush || (stall[3] == STOP && stall[4] == NO_STOP)) begin
            r_d     = '0;
            fresh_d = 1'b0;
        end else if (stall[3] == NO_STOP) begin
            r_d     = ex_mem_t'(ex_to_mem_bus);
            fresh_d = 1'b1;
        end
    end

    mem_stage_load_align u_align (
        .rdata  (data_sram_rdata),
        .sel    (r_q.data_ram_sel),
        .lb     (r_q.inst_lb),
        .lbu    (r_q.inst_lbu),
        .lh     (r_q.inst_lh),
        .lhu    (r_q.inst_lhu),
        .result (load_res)
    );

    assign exc_hit          = r_q.excepttype != EXC_NONE;
    assign exc_valid        = exc_hit & fresh_q & ~flush;
    assign exc_code         = exc_hit ? r_q.excepttype : 5'd0;
    assign exc_pc           = exc_hit ? r_q.pc : 32'd0;
    assign exc_badvaddr     = exc_hit ? r_q.badvaddr : 32'd0;
    assign exc_in_delayslot = exc_hit & r_q.in_delayslot;
    assign rf_we            = r_q.rf_we & ~exc_hit;
    assign hi_we            = r_q.hi_we & ~exc_hit;
    assign lo_we            = r_q.lo_we & ~exc_hit;
    assign cp0_we           = r_q.cp0_we & ~exc_hit;
    assign rf_wdata         = r_q.sel_rf_res ? load_res : r_q.ex_result;
    assign mem_fwd_bus      = {rf_we, r_q.rf_waddr, rf_wdata};
    assign mem_hilo_fwd     = {hi_we, r_q.hi_wdata, lo_we, r_q.lo_wdata};
    assign mem_to_wb_bus    = {r_q.pc, cp0_we, r_q.cp0_addr, r_q.cp0_sel, r_q.cp0_wdata,
                               mem_hilo_fwd, mem_fwd_bus};
    assign unused           = ^{r_q.data_ram_wen, r_q.data_ram_en, stall[5], stall[2:0]};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with a queue-based scoreboard checked by a negedge monitor.
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [5:0]   stall = '0;
    logic [228:0] bus = '0;
    logic [31:0]  rdata = '0;
    logic [176:0] wb;
    logic [37:0]  fwd;
    logic [65:0]  hilo;
    logic         exc_valid, exc_in_delayslot;
    logic [4:0]   exc_code;
    logic [31:0]  exc_pc, exc_badvaddr;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic         done = 1'b0;

    typedef struct {
        int          at;
        int          kind;
        logic [65:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .stall            (stall),
        .ex_to_mem_bus    (bus),
        .data_sram_rdata  (rdata),
        .mem_to_wb_bus    (wb),
        .mem_fwd_bus      (fwd),
        .mem_hilo_fwd     (hilo),
        .exc_valid        (exc_valid),
        .exc_code         (exc_code),
        .exc_pc           (exc_pc),
        .exc_badvaddr     (exc_badvaddr),
        .exc_in_delayslot (exc_in_delayslot)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [228:0] mk(input logic [4:0] exc, input logic [31:0] pc,
                                        input logic [3:0] sel, input logic [3:0] ldf,
                                        input logic hwe, input logic [31:0] hi,
                                        input logic srf, input logic rwe,
                                        input logic [4:0] wa, input logic [31:0] res);
        return {32'h0000_1001, exc, 1'b0, pc, 1'b0, 5'd0, 3'd0, 32'd0, sel, ldf,
                hi, hwe, 32'd0, 1'b0, 4'd0, 1'b0, srf, rwe, wa, res};
    endfunction

    function automatic logic [65:0] actual(input int k);
        case (k)
            0: return {34'd0, wb[31:0]};
            1: return {28'd0, fwd};
            2: return {65'd0, exc_valid};
            3: return {61'd0, exc_code};
            4: return {65'd0, wb[37]};
            5: return {65'd0, hilo[65]};
            6: return {65'd0, |{wb, fwd, hilo, exc_valid, exc_code, exc_pc, exc_badvaddr, exc_in_delayslot}};
            default: return {34'd0, exc_pc};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at <= cyc) begin
            exp_t e;
            logic [65:0] a;
            e = sb.pop_front();
            a = actual(e.kind);
            total++;
            if (a !== e.val) begin
                bad++;
                $display("FAIL %s: got %h, want %h", e.name, a, e.val);
            end
        end
        if (done && sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    end

    task automatic chk(input int k, input logic [65:0] v, input string n);
        exp_t e;
        e.at = cyc;
        e.kind = k;
        e.val = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [228:0] b, input logic [31:0] rd, input logic [31:0] ev, input string n);
        bus = b;
        stall = '0;
        tick();
        bus = '0;
        rdata = rd;
        chk(0, {34'd0, ev}, n);
        @(negedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk(6, 0, "rst_zero");
        chk(2, 0, "rst_excv");
        @(negedge clk);
        #1;
        rst = 1'b0;
        ld(mk(0, 32'h100, 4'b0100, 4'b1000, 0, 0, 1, 1, 3, 0), 32'h1280_3456, 32'hFFFF_FF80, "lb_b2");
        ld(mk(0, 32'h104, 4'b0100, 4'b0100, 0, 0, 1, 1, 3, 0), 32'h1280_3456, 32'h0000_0080, "lbu_b2");
        ld(mk(0, 32'h108, 4'b1100, 4'b0010, 0, 0, 1, 1, 3, 0), 32'h8001_7FFF, 32'hFFFF_8001, "lh_hi");
        ld(mk(0, 32'h10C, 4'b0011, 4'b0001, 0, 0, 1, 1, 3, 0), 32'h8001_7FFF, 32'h0000_7FFF, "lhu_lo");
        ld(mk(0, 32'h110, 4'b0001, 4'b1000, 0, 0, 1, 1, 3, 0), 32'h0000_00FF, 32'hFFFF_FFFF, "lb_b0");
        ld(mk(0, 32'h114, 4'b1000, 4'b1000, 0, 0, 1, 1, 3, 0), 32'h8000_0000, 32'hFFFF_FF80, "lb_b3");
        ld(mk(0, 32'h118, 4'b0010, 4'b1000, 0, 0, 1, 1, 3, 0), 32'h0000_7F00, 32'h0000_007F, "lb_b1");
        ld(mk(0, 32'h11C, 4'b1111, 4'b0000, 0, 0, 1, 1, 3, 0), 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");
        ld(mk(0, 32'h120, 4'b1111, 4'b0000, 0, 0, 0, 1, 3, 32'h1234), 32'hDEAD_BEEF, 32'h0000_1234, "alu_res");
        bus = mk(5'd12, 32'h400, 0, 0, 0, 0, 0, 1, 7, 32'h55);
        stall = '0;
        tick();
        bus = '0;
        stall = 6'b011111;
        chk(2, 1, "ov_excv1");
        chk(3, 12, "ov_code1");
        chk(4, 0, "ov_rfwe1");
        chk(7, 32'h400, "ov_pc");
        tick();
        chk(2, 0, "ov_excv2");
        chk(3, 12, "ov_code2");
        chk(4, 0, "ov_rfwe2");
        tick();
        chk(2, 0, "ov_excv3");
        chk(4, 0, "ov_rfwe3");
        @(negedge clk);
        #1;
        stall = '0;
        bus = mk(0, 32'h500, 0, 0, 0, 0, 0, 1, 5, 32'd7);
        tick();
        chk(1, {1'b1, 5'd5, 32'd7}, "add_fwd");
        stall = 6'b001111;
        bus = mk(0, 32'h504, 0, 0, 0, 0, 0, 1, 6, 32'd9);
        tick();
        chk(1, 0, "bubble_fwd");
        @(negedge clk);
        #1;
        stall = '0;
        bus = mk(5'd4, 32'h800, 0, 0, 0, 0, 0, 1, 8, 32'd3);
        tick();
        flush = 1'b1;
        bus = mk(0, 32'h804, 0, 0, 0, 0, 0, 1, 9, 32'd1);
        chk(2, 0, "flush_excv");
        chk(3, 4, "flush_code");
        tick();
        flush = 1'b0;
        bus = '0;
        chk(6, 0, "flush_clear");
        @(negedge clk);
        #1;
        bus = mk(0, 32'hC00, 0, 0, 1, 32'hABCD, 0, 0, 0, 0);
        tick();
        bus = '0;
        stall = 6'b011111;
        chk(5, 1, "mthi_we");
        tick();
        chk(5, 1, "mthi_hold");
        tick();
        rst = 1'b1;
        chk(6, 0, "rst_async_zero");
        chk(5, 0, "rst_hiwe");
        #2;
        rst = 1'b0;
        tick();
        chk(6, 0, "post_rst_bubble");
        @(negedge clk);
        #1;
        stall = '0;
        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
